// File: rtl/op_pkg.sv
// Shared front-end types and defaults for the fetch queue.
package op_pkg;

  localparam int unsigned INSTRUCTION_WIDTH  = 32;
  localparam int unsigned SUPER_SCALAR_WIDTH = 2;
  localparam int unsigned FETCH_QUEUE_DEPTH  = 8;
  localparam int unsigned PC_WIDTH           = 64;

  // One queued fetch slot: instruction word plus its PC.
  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]          pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer between fetch and decode, up to SSW entries
// in and out per cycle, flushed on misprediction.
// Optional macro FETCH_QUEUE_PERF_EN adds a saturating stall-cycle counter.
module fetch_queue #(
  parameter int unsigned INSTRUCTION_WIDTH  = op_pkg::INSTRUCTION_WIDTH,
  parameter int unsigned SUPER_SCALAR_WIDTH = op_pkg::SUPER_SCALAR_WIDTH,
  parameter int unsigned DEPTH              = op_pkg::FETCH_QUEUE_DEPTH
) (
  input  logic                                                clk_in,
  input  logic                                                rst_in,
  input  logic                                                flush_in,
  input  logic                                                enq_valid_in,
  input  logic [$clog2(SUPER_SCALAR_WIDTH+1)-1:0]             enq_count_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] enq_instr_in,
  input  logic [63:0]                                         enq_pc_in,
  output logic                                                enq_ready_out,
  input  logic                                                deq_ready_in,
  output logic                                                deq_valid_out,
  output logic [$clog2(SUPER_SCALAR_WIDTH+1)-1:0]             deq_count_out,
  output logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] deq_instr_out,
  output logic [SUPER_SCALAR_WIDTH-1:0][63:0]                 deq_pc_out,
  output logic [$clog2(DEPTH+1)-1:0]                          occupancy_out
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                                         stall_cycles_out
`endif
);

  localparam int unsigned SSW = SUPER_SCALAR_WIDTH;
  localparam int unsigned CW  = $clog2(SSW + 1);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned OW  = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;

  logic [INSTRUCTION_WIDTH-1:0] instr_q [DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] instr_d [DEPTH];
  logic [63:0]                  pc_q    [DEPTH];
  logic [63:0]                  pc_d    [DEPTH];

  logic          enq_fire;
  logic          deq_fire;
  logic [CW-1:0] enq_n;
  logic [CW-1:0] deq_n;

  // Handshake status from current occupancy only; a same-cycle pop gives no credit.
  always_comb begin
    enq_ready_out = ((OW'(DEPTH) - occ_q) >= OW'(SSW)) && !flush_in;
    deq_valid_out = (occ_q != '0) && !flush_in;
    deq_count_out = '0;
    if (deq_valid_out) begin
      deq_count_out = (occ_q >= OW'(SSW)) ? CW'(SSW) : CW'(occ_q);
    end
    enq_fire = enq_valid_in && enq_ready_out;
    deq_fire = deq_valid_out && deq_ready_in;
    enq_n    = '0;
    if (enq_fire) begin
      enq_n = (enq_count_in > CW'(SSW)) ? CW'(SSW) : enq_count_in;
    end
    deq_n = deq_fire ? deq_count_out : '0;
  end

  // Offer the oldest entries from head, zeroing slots beyond deq_count_out.
  always_comb begin
    for (int i = 0; i < SSW; i++) begin
      deq_instr_out[i] = '0;
      deq_pc_out[i]    = '0;
      if (CW'(i) < deq_count_out) begin
        deq_instr_out[i] = instr_q[PW'(head_q + PW'(i))];
        deq_pc_out[i]    = pc_q[PW'(head_q + PW'(i))];
      end
    end
  end

  // Next pointer and occupancy state; flush overrides any transfer.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush_in) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      head_d = PW'(head_q + PW'(deq_n));
      tail_d = PW'(tail_q + PW'(enq_n));
      occ_d  = OW'(occ_q + OW'(enq_n) - OW'(deq_n));
    end
  end

  // Write accepted bundle slots in order starting at tail.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    for (int i = 0; i < SSW; i++) begin
      if (CW'(i) < enq_n) begin
        instr_d[PW'(tail_q + PW'(i))] = enq_instr_in[i];
        pc_d[PW'(tail_q + PW'(i))]    = 64'(enq_pc_in + 64'(4 * i));
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Entry storage; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge clk_in) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

  assign occupancy_out = occ_q;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Count cycles where fetch is held off by a full queue; saturate at max.
  always_comb begin
    stall_d = stall_q;
    if (enq_valid_in && !enq_ready_out && !flush_in && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_out = stall_q;
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be: INSTRUCTION_WIDTH, default op_pkg::INSTRUCTION_WIDTH, instruction bits; SUPER_SCALAR_WIDTH, default op_pkg::SUPER_SCALAR_WIDTH, max instructions per cycle; DEPTH, default 8, entries, power of two and >= 2*SUPER_SCALAR_WIDTH.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; ports are listed below with clock and reset first.
REQ-003 clk_in  in  1  clock, rising edge.
REQ-004 rst_in  in  1  reset, asynchronous, active-high.
REQ-005 flush_in  in  1  misprediction flush; empties the queue.
REQ-006 enq_valid_in  in  1  fetch bundle valid.
REQ-007 enq_count_in  in  $clog2(SSW+1)  number of valid bundle slots, slot 0 first.
REQ-008 enq_instr_in  in  [SSW][INSTRUCTION_WIDTH]  fetched instructions.
REQ-009 enq_pc_in  in  64  PC of slot 0; PC of slot i is enq_pc_in + 4*i, mod 2^64.
REQ-010 enq_ready_out  out  1  queue can take a full bundle.
REQ-011 deq_ready_in  in  1  decode accepts this cycle.
REQ-012 deq_valid_out  out  1  at least one entry is offered.
REQ-013 deq_count_out  out  $clog2(SSW+1)  number of entries offered.
REQ-014 deq_instr_out, deq_pc_out  out  [SSW][INSTRUCTION_WIDTH], [SSW][64]  oldest entries, slot 0 oldest.
REQ-015 occupancy_out  out  $clog2(DEPTH+1)  current entry count.

Function
REQ-016 The queue SHALL be a circular buffer with head and tail pointers that wrap modulo DEPTH, plus a registered occupancy count.
REQ-017 enq_ready_out SHALL equal (DEPTH - occupancy >= SSW) && !flush_in, computed from current-cycle occupancy only; a same-cycle dequeue gives no credit.
REQ-018 An enqueue fires when enq_valid_in && enq_ready_out; it writes min(enq_count_in, SSW) entries in slot order at tail, and tail advances by the same amount.
REQ-019 enq_count_in = 0 with enq_valid_in = 1 SHALL be a no-op.
REQ-020 deq_valid_out SHALL be (occupancy != 0) && !flush_in, and deq_count_out SHALL be min(occupancy, SSW), or 0 when deq_valid_out is 0.
REQ-021 Offered slots SHALL be read combinationally from registered storage at head..head+deq_count_out-1, with wrap.
REQ-022 Unoffered slots SHALL drive all-zero instruction and PC.
REQ-023 A dequeue fires when deq_valid_out && deq_ready_in and pops deq_count_out entries; partial acceptance is not supported.
REQ-024 Simultaneous enqueue and dequeue SHALL update occupancy to occ + enq_n - deq_n in one edge.
REQ-025 Latency: an entry written at edge N SHALL be offered no earlier than the cycle following edge N; there is no bypass.
REQ-026 Order SHALL be strict FIFO across bundles and across pointer wrap.
REQ-027 When flush_in = 1 at an edge, head, tail and occupancy SHALL become 0, and any enqueue or dequeue in that cycle is discarded.
REQ-028 When flush_in = 1, outputs SHALL show deq_valid_out = 0 and enq_ready_out = 0 in that same cycle.

Reset
REQ-029 While rst_in = 1, independent of clk_in: head = tail = occupancy = 0, deq_valid_out = 0, deq_count_out = 0, and enq_ready_out = 1 once flush_in = 0.
REQ-030 Storage contents SHALL NOT require reset.
REQ-031 Reset asserted mid-transfer SHALL drop all in-flight entries.

Configuration
REQ-032 When FETCH_QUEUE_PERF_EN is defined, port stall_cycles_out (out, 32) SHALL exist; it counts cycles with enq_valid_in && !enq_ready_out && !flush_in, saturates at 2^32-1, and resets to 0 only on rst_in.
REQ-033 When FETCH_QUEUE_PERF_EN is undefined, the port and its counter SHALL be absent.

Structure
REQ-034 The typedef fetch_entry_t {instr, pc} and the constant FETCH_QUEUE_DEPTH SHALL live in op_pkg.
REQ-035 No sub-module is required; storage, pointers and the counter SHALL be inline in fetch_queue.

Verification (SSW=2, DEPTH=8)
REQ-036 Reset, then enqueue count=2, pc=0x1000, instrs A,B with deq_ready_in=0 -> next cycle deq_valid_out=1, deq_count_out=2, PCs 0x1000/0x1004, occupancy_out=2.
REQ-037 Fill 4 bundles of 2 with deq_ready_in=0 -> occupancy_out=8, enq_ready_out=0; at occupancy 7, enq_ready_out=0; at occupancy 6, enq_ready_out=1.
REQ-038 Occupancy 1, enqueue 2 and dequeue in the same cycle -> deq_count_out=1 popped, occupancy_out=2 next cycle, order preserved.
REQ-039 Stream 20 single-entry bundles with PCs 0x0,0x4,... while decode alternates ready -> output order matches input across the wrap at 8.
REQ-040 Occupancy 5, flush_in=1 with enqueue valid -> that cycle deq_valid_out=0; next cycle occupancy_out=0 and the enqueued bundle is absent.
REQ-041 With FETCH_QUEUE_PERF_EN, hold a full queue with enq_valid_in=1 for 10 cycles -> stall_cycles_out=10.
